// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder shared over WIDTH clock cycles.
// The operands are latched on start and fed to the adder LSB-first. The carry
// is held in a flop between bits. Sum bits enter a shift register at its MSB.
// Optional build macro: SERIAL_ADDER_SUB_EN adds a 'sub' input. When 'sub' is
// high, the block computes a - b as a + ~b + 1, and cout=1 means no borrow.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one bit pair per clock, WIDTH edges total
// DONE  | one-cycle done pulse; start here chains the next operation

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               sub_sel;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   s_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Outputs decode straight from the state register, with no input paths.
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign last_bit = (cnt == CNT_LAST);
    assign s_next   = {fa_s, s_sh[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Start is honoured only in IDLE and DONE.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, bit-serial shift and result capture on the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub_sel ? ~b : b;
            carry <= sub_sel ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_next;
            carry <= fa_co;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= s_next;
                cout <= fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl with WIDTH=7.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] a = '0;
    logic [6:0] b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [6:0] sum;
    logic       cout;

    int pass_cnt = 0;
    int total    = 0;

    int         busy_n;
    int         done_n;
    int         done_at;
    logic [6:0] done_sum;
    logic       done_cout;

    serial_adder_ctrl #(.WIDTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge, then observe a fixed window of negedges.
    // Index 0 is the negedge right after the accepting edge E0.
    task automatic run_op(input logic [6:0] av, input logic [6:0] bv,
                          input logic ci, input int ncyc);
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1; done_sum = 'x; done_cout = 1'bx;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i; done_sum = sum; done_cout = cout;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++;
        if ({busy, done, sum, cout} !== 10'b0)
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b required all 0",
                     busy, done, sum, cout);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_overflow();
        run_op(7'h7F, 7'h01, 1'b0, 12);
        total++;
        if (busy_n !== 7) $display("FAIL t1_busy_len: got %0d required 7", busy_n);
        else pass_cnt++;
        total++;
        if (done_at !== 7 || done_n !== 1)
            $display("FAIL t1_done_timing: at=%0d n=%0d required at=7 n=1", done_at, done_n);
        else pass_cnt++;
        total++;
        if (done_sum !== 7'h00 || done_cout !== 1'b1)
            $display("FAIL t1_result: sum=%h cout=%b required sum=00 cout=1", done_sum, done_cout);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int bad = 0;
        run_op(7'd25, 7'd36, 1'b1, 10);
        total++;
        if (done_sum !== 7'd62 || done_cout !== 1'b0)
            $display("FAIL t2_result: sum=%0d cout=%b required sum=62 cout=0", done_sum, done_cout);
        else pass_cnt++;
        total++;
        if (done_n !== 1) $display("FAIL t2_done_len: got %0d required 1", done_n);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sum !== 7'd62 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL t2_idle_hold: %0d bad cycles, required 0 (sum=62 held)", bad);
        else pass_cnt++;
    endtask

    task automatic test_start_during_run();
        int dn = 0;
        int held_bad = 0;
        logic [6:0] rs = 'x;
        @(negedge clk);
        a = 7'd3; b = 7'd4; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && (sum !== 7'd62 || cout !== 1'b0)) held_bad++;
            if (done) begin dn++; rs = sum; end
            if (i == 1) begin start = 1'b1; a = 7'd100; b = 7'd100; end
            if (i == 2) start = 1'b0;
        end
        total++;
        if (held_bad != 0) $display("FAIL t3_sum_held_in_run: %0d bad cycles required 0", held_bad);
        else pass_cnt++;
        total++;
        if (dn !== 1) $display("FAIL t3_done_count: got %0d required 1", dn);
        else pass_cnt++;
        total++;
        if (rs !== 7'd7 || cout !== 1'b0)
            $display("FAIL t3_result: sum=%0d cout=%b required sum=7 cout=0", rs, cout);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int dn = 0;
        @(negedge clk);
        a = 7'd50; b = 7'd60; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || sum !== 7'd0 || cout !== 1'b0)
            $display("FAIL t4_abort: busy=%b sum=%0d cout=%b required 0/0/0", busy, sum, cout);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        total++;
        if (dn !== 0) $display("FAIL t4_no_done: %0d active cycles required 0", dn);
        else pass_cnt++;
        run_op(7'd1, 7'd2, 1'b0, 10);
        total++;
        if (done_sum !== 7'd3 || done_cout !== 1'b0 || done_at !== 7)
            $display("FAIL t4_recover: sum=%0d cout=%b at=%0d required sum=3 cout=0 at=7",
                     done_sum, done_cout, done_at);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int pos[$];
        logic [6:0] sums[$];
        @(negedge clk);
        a = 7'd10; b = 7'd5; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done) begin
                pos.push_back(i);
                sums.push_back(sum);
                if (pos.size() == 1) begin a = 7'd20; b = 7'd20; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (pos.size() != 2)
            $display("FAIL t5_done_count: got %0d required 2", pos.size());
        else pass_cnt++;
        if (pos.size() == 2) begin
            total++;
            if (pos[0] != 7 || pos[1] != 15)
                $display("FAIL t5_spacing: at %0d,%0d required 7,15", pos[0], pos[1]);
            else pass_cnt++;
            total++;
            if (sums[0] !== 7'd15 || sums[1] !== 7'd40)
                $display("FAIL t5_sums: %0d,%0d required 15,40", sums[0], sums[1]);
            else pass_cnt++;
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        sub = 1'b1;
        run_op(7'd10, 7'd3, 1'b0, 10);
        total++;
        if (done_sum !== 7'd7 || done_cout !== 1'b1)
            $display("FAIL t6_sub_pos: sum=%h cout=%b required sum=07 cout=1", done_sum, done_cout);
        else pass_cnt++;
        run_op(7'd3, 7'd10, 1'b1, 10);
        total++;
        if (done_sum !== 7'h79 || done_cout !== 1'b0)
            $display("FAIL t6_sub_neg: sum=%h cout=%b required sum=79 cout=0", done_sum, done_cout);
        else pass_cnt++;
        sub = 1'b0;
        run_op(7'd10, 7'd3, 1'b1, 10);
        total++;
        if (done_sum !== 7'd14 || done_cout !== 1'b0)
            $display("FAIL t6_add_mode: sum=%0d cout=%b required sum=14 cout=0", done_sum, done_cout);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_overflow();
        test_hold();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
